// File: rtl/key_pio_pkg.sv
// Shared constants for the key/switch input PIO: register word addresses,
// edge-type encodings and the prime counter's terminal value.
package key_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam logic [1:0] PRIME_MAX = 2'd3;

endpackage

// File: rtl/key_debounce.sv
// Single-bit debounce filter: the output follows the synchronised input only
// after the input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    input  logic sync_i,
    output logic filt_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    // Any agreeing cycle, or the cycle the change is accepted, restarts the count.
    always_comb begin
        cnt_d  = '0;
        filt_d = filt_q;
        if (en_i && (sync_i != filt_q)) begin
            if (cnt_q == LAST) begin
                filt_d = sync_i;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/key_input_pio.sv
// Avalon-MM parallel input port with synchroniser, edge capture and maskable
// level interrupt. Define KEY_PIO_DEBOUNCE_EN to add a per-bit debounce filter.
module key_input_pio
    import key_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 1,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] meta_q, sync_q, filt, prev_q;
    logic [WIDTH-1:0] edge_det, wr_clr;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [1:0]       prime_q, prime_d;
    logic             primed;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en, rd_en;
    logic             unused_bits;

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        zext            = '0;
        zext[WIDTH-1:0] = v;
    endfunction

    assign wr_en  = chipselect && !write_n;
    assign rd_en  = chipselect && !read_n;
    assign primed = (prime_q == PRIME_MAX);

`ifdef KEY_PIO_DEBOUNCE_EN
    for (genvar g = 0; g < WIDTH; g++) begin : g_deb
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .en_i   (primed),
            .sync_i (sync_q[g]),
            .filt_o (filt[g])
        );
    end
    assign unused_bits = ^writedata;
`else
    assign filt        = sync_q;
    assign unused_bits = ^{writedata, DEBOUNCE_CYCLES};
`endif

    // Edges are ignored until the synchroniser and prev register hold real samples.
    always_comb begin
        edge_det = '0;
        if (primed) begin
            if (EDGE_TYPE == EDGE_RISE) begin
                edge_det = filt & ~prev_q;
            end else if (EDGE_TYPE == EDGE_FALL) begin
                edge_det = ~filt & prev_q;
            end else begin
                edge_det = filt ^ prev_q;
            end
        end
    end

    always_comb begin
        prime_d    = primed ? prime_q : prime_q + 2'd1;
        wr_clr     = '0;
        irqmask_d  = irqmask_q;
        readdata_d = readdata_q;
        if (wr_en && (address == ADDR_EDGECAP)) begin
            wr_clr = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        // A new edge outranks a simultaneous write-1-to-clear.
        edgecap_d = (edgecap_q & ~wr_clr) | edge_det;
        if (rd_en) begin
            case (address)
                ADDR_DATA:    readdata_d = zext(filt);
                ADDR_IRQMASK: readdata_d = zext(irqmask_q);
                ADDR_EDGECAP: readdata_d = zext(edgecap_q);
                default:      readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q     <= '0;
            sync_q     <= '0;
            prev_q     <= '0;
            prime_q    <= '0;
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            readdata_q <= '0;
        end else begin
            meta_q     <= in_port;
            sync_q     <= meta_q;
            prev_q     <= filt;
            prime_q    <= prime_d;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_key_input_pio.sv
// Bench for key_input_pio (WIDTH=4, falling-edge capture); directed scenarios
// plus, in the default build, randomized traffic against a reference model.
module tb_key_input_pio;

    localparam int WIDTH     = 4;
    localparam int EDGE_TYPE = 1;
    localparam int DEB       = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    key_input_pio #(
        .WIDTH          (WIDTH),
        .EDGE_TYPE      (EDGE_TYPE),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .read_n    (read_n),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Bus tasks are called at a falling edge; the access happens on the next rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        @(negedge clk);
        chipselect = 1'b0; read_n = 1'b1;
        d = readdata;
    endtask

`ifndef KEY_PIO_DEBOUNCE_EN
    // Reference model: filt is the input seen two clocks earlier, prev three;
    // edges count only from the fourth clock after reset release.
    int          m_n;
    logic [3:0]  hist [8];
    logic [3:0]  m_cap, m_mask, m_f, m_p, m_edg, m_clr;
    logic [31:0] m_rd, m_rd_nx;

    function automatic logic [3:0] edge_of(input logic [3:0] f, input logic [3:0] p);
        case (EDGE_TYPE)
            0:       return f & ~p;
            1:       return ~f & p;
            default: return f ^ p;
        endcase
    endfunction

    always_comb begin
        m_f     = (m_n >= 2) ? hist[3'(m_n - 1)] : 4'h0;
        m_p     = (m_n >= 3) ? hist[3'(m_n - 2)] : 4'h0;
        m_edg   = (m_n >= 3) ? edge_of(m_f, m_p) : 4'h0;
        m_clr   = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
        m_rd_nx = m_rd;
        if (chipselect && !read_n) begin
            case (address)
                2'd0:    m_rd_nx = {28'h0, m_f};
                2'd2:    m_rd_nx = {28'h0, m_mask};
                2'd3:    m_rd_nx = {28'h0, m_cap};
                default: m_rd_nx = 32'h0;
            endcase
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_n    <= 0;
            m_cap  <= 4'h0;
            m_mask <= 4'h0;
            m_rd   <= 32'h0;
        end else begin
            m_n               <= m_n + 1;
            hist[3'(m_n + 1)] <= in_port;
            m_cap             <= (m_cap & ~m_clr) | m_edg;
            if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[3:0];
            m_rd              <= m_rd_nx;
        end
    end
`endif

    initial begin
        logic [31:0] d;
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; read_n = 1'b1;
        write_n = 1'b1; writedata = 32'h0; in_port = 4'hF;
        #1;
        chk("reset_irq", {31'h0, irq}, 32'h0);
        chk("reset_readdata", readdata, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

`ifdef KEY_PIO_DEBOUNCE_EN
        repeat (20) @(negedge clk);
        bus_read(2'd3, d); chk("deb_boot_edgecap", d, 32'h0);
        bus_read(2'd0, d); chk("deb_boot_data", d, 32'hF);
        bus_write(2'd2, 32'h1);
        in_port = 4'hE;
        repeat (5) @(negedge clk);
        in_port = 4'hF;
        repeat (15) @(negedge clk);
        bus_read(2'd0, d); chk("deb_glitch_data", d, 32'hF);
        bus_read(2'd3, d); chk("deb_glitch_edgecap", d, 32'h0);
        chk("deb_glitch_irq", {31'h0, irq}, 32'h0);
        in_port = 4'hE;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (k == 10) chk("deb_hold_irq_early", {31'h0, irq}, 32'h0);
            if (k == 11) chk("deb_hold_irq", {31'h0, irq}, 32'h1);
        end
        bus_read(2'd0, d); chk("deb_hold_data", d, 32'hE);
        bus_read(2'd3, d); chk("deb_hold_edgecap", d, 32'h1);
`else
        repeat (10) @(negedge clk);
        bus_read(2'd3, d); chk("boot_edgecap", d, 32'h0);
        bus_read(2'd0, d); chk("boot_data", d, 32'hF);
        chk("boot_irq", {31'h0, irq}, 32'h0);

        bus_write(2'd2, 32'h4);
        in_port = 4'hB;
        repeat (2) @(negedge clk);
        chk("fall2_irq_early", {31'h0, irq}, 32'h0);
        @(negedge clk);
        chk("fall2_irq", {31'h0, irq}, 32'h1);
        bus_read(2'd3, d); chk("fall2_edgecap", d, 32'h4);
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, d); chk("w1c_edgecap", d, 32'h0);
        chk("w1c_irq", {31'h0, irq}, 32'h0);

        in_port = 4'hA;
        repeat (4) @(negedge clk);
        chk("fall0_masked_irq", {31'h0, irq}, 32'h0);
        bus_read(2'd3, d); chk("fall0_edgecap", d, 32'h1);
        bus_write(2'd2, 32'h1);
        chk("unmask_irq", {31'h0, irq}, 32'h1);

        in_port = 4'hE;
        repeat (5) @(negedge clk);
        bus_write(2'd3, 32'hF);
        bus_read(2'd3, d); chk("rise_ignored_edgecap", d, 32'h0);
        in_port = 4'hA;
        repeat (2) @(negedge clk);
        bus_write(2'd3, 32'h4);
        bus_read(2'd3, d); chk("set_beats_clear", d, 32'h4);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) in_port = 4'($urandom);
            case ($urandom_range(3))
                0: @(negedge clk);
                1: bus_write(2'd2, $urandom);
                2: bus_write(2'd3, $urandom);
                default: begin
                    bus_read(2'($urandom), d);
                    chk("rand_readdata", d, m_rd);
                end
            endcase
            chk("rand_irq", {31'h0, irq}, {31'h0, |(m_cap & m_mask)});
        end
`endif

        in_port = 4'h5;
        repeat (20) @(negedge clk);
        bus_read(2'd1, d); chk("reserved_read", d, 32'h0);
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_read(2'd0, d); chk("data_write_ignored", d, 32'h5);
        in_port = 4'h0;
        repeat (20) @(negedge clk);
        bus_write(2'd2, 32'hF);
        chk("pre_reset_irq", {31'h0, irq}, 32'h1);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst_irq", {31'h0, irq}, 32'h0);
        chk("midrst_readdata", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(2'd2, d); chk("midrst_irqmask", d, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
